// File: rtl/clock_display_pkg.sv
// clock_display_pkg: shared constants and types for the
// six-digit clock display scanner and hourly chime.
package clock_display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [5:0] AN_OFF  = 6'h3F;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Decimal points sit after hour units and minute units
  localparam logic [5:0] DP_DIGITS = 6'b010100;

  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    BZ_IDLE,
    BZ_ON,
    BZ_OFF
  } buzz_state_t;

  function automatic logic [5:0] digit_sel(
    input logic [2:0] idx
  );
    return ~(6'd1 << idx);
  endfunction

endpackage

// File: rtl/clock_display_scan_if.sv
// clock_display_scan_if: time inputs, scan enable,
// chime request and display/buzzer outputs.
interface clock_display_scan_if;

  logic       en;
  logic [7:0] hour;
  logic [7:0] min;
  logic [7:0] sec;
  logic       tweet;
  logic [5:0] an;
  logic [7:0] seg;
  logic       buzzer;

  modport master (
    output en, hour, min, sec, tweet,
    input  an, seg, buzzer
  );

  modport slave (
    input  en, hour, min, sec, tweet,
    output an, seg, buzzer
  );

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble to active-low 7-segment
// pattern; non-decimal nibbles render blank.
module seg7_decode
  import clock_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  always_comb begin
    pat = SEG_BLANK;
    case (nib)
      4'd0: pat = SEG_0;
      4'd1: pat = SEG_1;
      4'd2: pat = SEG_2;
      4'd3: pat = SEG_3;
      4'd4: pat = SEG_4;
      4'd5: pat = SEG_5;
      4'd6: pat = SEG_6;
      4'd7: pat = SEG_7;
      4'd8: pat = SEG_8;
      4'd9: pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// clock_display_scan: multiplexed hh.mm.ss display
// scanner with tear-free frames and an hourly chime.
module clock_display_scan
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int BEEP_LEN = 8,
  parameter int BEEP_NUM = 2
) (
  input logic clk,
  input logic rst_n,
  clock_display_scan_if.slave io
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int TW = $clog2(BEEP_LEN + 1);
  localparam int BW = $clog2(BEEP_NUM + 1);

  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] T_LAST = TW'(BEEP_LEN - 1);
  localparam logic [BW-1:0] B_NUM  = BW'(BEEP_NUM);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [23:0]   snap;
  logic          tick;
  logic [3:0]    nib;
  logic [6:0]    pat;
  logic [5:0]    an_q;
  logic [7:0]    seg_q;

  assign tick = io.en && (presc == P_LAST);

  // Snapshot refreshes only at the frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= P_LAST;
      idx   <= LAST_DIGIT;
      snap  <= '0;
    end else if (io.en) begin
      if (tick) begin
        presc <= '0;
        if (idx == LAST_DIGIT) begin
          idx  <= 3'd0;
          snap <= {io.hour, io.min, io.sec};
        end else begin
          idx <= idx + 3'd1;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  always_comb begin
    nib = snap[3:0];
    case (idx)
      3'd1: nib = snap[7:4];
      3'd2: nib = snap[11:8];
      3'd3: nib = snap[15:12];
      3'd4: nib = snap[19:16];
      3'd5: nib = snap[23:20];
      default: nib = snap[3:0];
    endcase
  end

  seg7_decode u_dec (
    .nib (nib),
    .pat (pat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
    end else if (!io.en) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
    end else begin
      an_q  <= digit_sel(idx);
      seg_q <= {~DP_DIGITS[idx], pat};
    end
  end

  assign io.an  = an_q;
  assign io.seg = seg_q;

  buzz_state_t   state;
  logic [TW-1:0] timer;
  logic [BW-1:0] beeps;
  logic          tweet_q;
  logic          buz_q;
  logic          tweet_rise;

  assign tweet_rise = io.tweet && !tweet_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BZ_IDLE;
      timer   <= '0;
      beeps   <= '0;
      tweet_q <= 1'b0;
      buz_q   <= 1'b0;
    end else begin
      tweet_q <= io.tweet;
      unique case (state)
        BZ_IDLE: begin
          if (tweet_rise) begin
            state <= BZ_ON;
            timer <= '0;
            beeps <= '0;
            buz_q <= 1'b1;
          end
        end
        BZ_ON: begin
          if (timer == T_LAST) begin
            state <= BZ_OFF;
            timer <= '0;
            beeps <= beeps + BW'(1);
            buz_q <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        BZ_OFF: begin
          if (timer == T_LAST) begin
            timer <= '0;
            if (beeps < B_NUM) begin
              state <= BZ_ON;
              buz_q <= 1'b1;
            end else begin
              state <= BZ_IDLE;
              beeps <= '0;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= BZ_IDLE;
          buz_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.buzzer = buz_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// tb_clock_display_scan: directed, table-driven checks
// of scanning, frame snapshot, enable gating and chime.
module tb_clock_display_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  clock_display_scan_if io ();

  clock_display_scan #(
    .SCAN_DIV (4),
    .BEEP_LEN (8),
    .BEEP_NUM (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(
    input string      name,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h",
                  name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs driven for a frame and the segments it must show
  typedef struct packed {
    logic [7:0]      hour;
    logic [7:0]      min;
    logic [7:0]      sec;
    logic [5:0][7:0] seg;
  } frame_vec_t;

  frame_vec_t      frames [3];
  logic [5:0][5:0] an_tab;
  int              f;
  int              d;
  logic            exp_b;

  initial begin
    an_tab = {6'h1F, 6'h2F, 6'h37,
              6'h3B, 6'h3D, 6'h3E};
    frames[0] = '{8'h12, 8'h34, 8'h56,
      {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82}};
    frames[1] = '{8'h12, 8'h34, 8'h56,
      {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82}};
    frames[2] = '{8'hA5, 8'h34, 8'h57,
      {8'hFF, 8'h12, 8'hB0, 8'h19, 8'h92, 8'hF8}};

    io.en    = 1'b0;
    io.tweet = 1'b0;
    io.hour  = 8'h00;
    io.min   = 8'h00;
    io.sec   = 8'h00;

    #2 rst_n = 1'b0;
    #1;
    check("rst an", {2'b0, io.an}, 8'h3F);
    check("rst seg", io.seg, 8'hFF);
    check("rst buzzer", {7'b0, io.buzzer}, 8'h00);

    io.hour = frames[0].hour;
    io.min  = frames[0].min;
    io.sec  = frames[0].sec;
    io.en   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Three frames; next frame's inputs change at digit 3
    for (int k = 1; k <= 73; k++) begin
      step();
      if (k == 1) begin
        check("first an", {2'b0, io.an}, 8'h1F);
        check("first seg", io.seg, 8'hC0);
      end else begin
        f = (k - 2) / 24;
        d = ((k - 2) % 24) / 4;
        check($sformatf("scan k%0d an", k),
              {2'b0, io.an}, {2'b0, an_tab[d]});
        check($sformatf("scan k%0d seg", k),
              io.seg, frames[f].seg[d]);
      end
      if ((k % 24) == 14 && (k / 24) + 1 < 3) begin
        io.hour = frames[k / 24 + 1].hour;
        io.min  = frames[k / 24 + 1].min;
        io.sec  = frames[k / 24 + 1].sec;
      end
    end

    // Reach index 3, prescaler 1, then gate off
    for (int k = 74; k <= 86; k++) step();
    io.en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("gate%0d an", k),
            {2'b0, io.an}, 8'h3F);
      check($sformatf("gate%0d seg", k),
            io.seg, 8'hFF);
    end
    io.en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("resume d3 %0d an", k),
            {2'b0, io.an}, 8'h37);
      check($sformatf("resume d3 %0d seg", k),
            io.seg, 8'hB0);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("resume d4 %0d an", k),
            {2'b0, io.an}, 8'h2F);
      check($sformatf("resume d4 %0d seg", k),
            io.seg, 8'h12);
    end

    // Chime with scan disabled; extra pulse ignored,
    // pulse after idle restarts
    io.en    = 1'b0;
    io.tweet = 1'b1;
    for (int k = 1; k <= 58; k++) begin
      step();
      if (k == 1)  io.tweet = 1'b0;
      if (k == 11) io.tweet = 1'b1;
      if (k == 12) io.tweet = 1'b0;
      if (k == 39) io.tweet = 1'b1;
      if (k == 40) io.tweet = 1'b0;
      if (k == 45) io.en = 1'b1;
      exp_b = (k <= 8) ||
              (k >= 17 && k <= 24) ||
              (k >= 40 && k <= 47) ||
              (k >= 56 && k <= 63);
      check($sformatf("chime k%0d", k),
            {7'b0, io.buzzer}, {7'b0, exp_b});
    end

    // Reset mid-beep and mid-scan acts at once
    #3;
    rst_n    = 1'b0;
    io.tweet = 1'b1;
    #1;
    check("mid rst an", {2'b0, io.an}, 8'h3F);
    check("mid rst seg", io.seg, 8'hFF);
    check("mid rst buzzer",
          {7'b0, io.buzzer}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rel tweet buzzer",
          {7'b0, io.buzzer}, 8'h01);
    check("rel an", {2'b0, io.an}, 8'h1F);
    check("rel seg", io.seg, 8'hC0);
    io.tweet = 1'b0;
    step();
    check("rel d0 an", {2'b0, io.an}, 8'h3E);
    check("rel d0 seg", io.seg, 8'hF8);
    check("rel buzzer hold",
          {7'b0, io.buzzer}, 8'h01);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
